// File: rtl/datapath_sequencer.sv
// Instruction FIFO plus issue/decode controller for the register-file / ALU / flags datapath.
// Words pop one per cycle in RUN; decoded controls are registered and held for one cycle.
module datapath_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        flush,
  input  logic        resume,
  output logic [15:0] reg_en,
  output logic [3:0]  reg_a,
  output logic [3:0]  reg_b,
  output logic [15:0] imm,
  output logic [1:0]  b_sel,
  output logic [3:0]  opcode,
  output logic        flag_en,
  output logic        halted,
  output logic [15:0] retired
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // halted doubles as the debug view of the FSM state.
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;
  state_t state_q, state_d;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [15:0]   head;

  // Handshake: a word transfers on any rising edge where instr_valid && instr_ready;
  // instr_ready depends only on FIFO occupancy, never on instr_valid.
  assign instr_ready = (count < FULL_COUNT);
  assign push        = instr_valid && instr_ready && !flush;
  assign pop         = (state_q == RUN) && (count != '0) && !flush;
  assign head        = mem[rd_ptr];
  assign halted      = (state_q == HALTED);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (pop && head[15:14] == 2'b11 && head[13]) state_d = HALTED;
        HALTED:  if (resume) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  logic [15:0] reg_en_d;
  logic [3:0]  reg_a_d, reg_b_d, opcode_d;
  logic [15:0] imm_d;
  logic [1:0]  b_sel_d;
  logic        flag_en_d;
  logic        retire_d;

  // Anything that is not a popped R/I/F word yields the all-zero idle control set.
  always_comb begin
    reg_en_d  = '0;
    reg_a_d   = '0;
    reg_b_d   = '0;
    imm_d     = '0;
    b_sel_d   = 2'd0;
    opcode_d  = '0;
    flag_en_d = 1'b0;
    retire_d  = 1'b0;
    if (pop) begin
      case (head[15:14])
        2'b00: begin
          reg_en_d  = head[0] ? 16'd0 : (16'd1 << head[9:6]);
          reg_a_d   = head[9:6];
          reg_b_d   = head[5:2];
          opcode_d  = head[13:10];
          flag_en_d = head[1];
          retire_d  = 1'b1;
        end
        2'b01: begin
          reg_en_d  = 16'd1 << head[9:6];
          reg_a_d   = head[9:6];
          imm_d     = {{10{head[5]}}, head[5:0]};
          b_sel_d   = 2'd1;
          opcode_d  = head[13:10];
          flag_en_d = 1'b1;
          retire_d  = 1'b1;
        end
        2'b10: begin
          reg_en_d  = head[0] ? 16'd0 : (16'd1 << head[9:6]);
          reg_a_d   = head[9:6];
          b_sel_d   = 2'd2;
          opcode_d  = head[13:10];
          flag_en_d = head[1];
          retire_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_en  <= '0;
      reg_a   <= '0;
      reg_b   <= '0;
      imm     <= '0;
      b_sel   <= '0;
      opcode  <= '0;
      flag_en <= 1'b0;
      retired <= '0;
    end else begin
      reg_en  <= reg_en_d;
      reg_a   <= reg_a_d;
      reg_b   <= reg_b_d;
      imm     <= imm_d;
      b_sel   <= b_sel_d;
      opcode  <= opcode_d;
      flag_en <= flag_en_d;
      retired <= retired + {15'd0, retire_d};
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: decode vector table plus HALT/fill, flush and reset sequences.
module tb_datapath_sequencer;

  localparam int DEPTH = 4;
  localparam logic [15:0] HALT_W = 16'hE000;

  logic        clk, rst;
  logic [15:0] instr;
  logic        instr_valid, instr_ready, flush, resume;
  logic [15:0] reg_en, imm, retired;
  logic [3:0]  reg_a, reg_b, opcode;
  logic [1:0]  b_sel;
  logic        flag_en, halted;

  datapath_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush), .resume(resume),
    .reg_en(reg_en), .reg_a(reg_a), .reg_b(reg_b), .imm(imm), .b_sel(b_sel),
    .opcode(opcode), .flag_en(flag_en), .halted(halted), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] reg_en;
    logic [3:0]  reg_a;
    logic [3:0]  reg_b;
    logic [15:0] imm;
    logic [1:0]  b_sel;
    logic [3:0]  opcode;
    logic        flag_en;
    logic        cnt;
  } vec_t;

  vec_t        t [7];
  logic [46:0] exp_q [$];
  logic [46:0] dut_ctl;
  logic [15:0] exp_ret;
  int          checks, errors;

  assign dut_ctl = {reg_en, reg_a, reg_b, imm, b_sel, opcode, flag_en};

  function automatic logic [46:0] pack_vec(input vec_t v);
    return {v.reg_en, v.reg_a, v.reg_b, v.imm, v.b_sel, v.opcode, v.flag_en};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_one(input logic [15:0] w);
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  initial begin
    // instr, reg_en, reg_a, reg_b, imm, b_sel, opcode, flag_en, counts
    t[0] = '{16'h0D10, 16'h0010, 4'd4,  4'd4,  16'h0000, 2'd0, 4'd3,  1'b0, 1'b1};
    t[1] = '{16'h44BF, 16'h0004, 4'd2,  4'd0,  16'hFFFF, 2'd1, 4'd1,  1'b1, 1'b1};
    t[2] = '{16'h4BD5, 16'h8000, 4'd15, 4'd0,  16'h0015, 2'd1, 4'd2,  1'b1, 1'b1};
    t[3] = '{16'h14DF, 16'h0000, 4'd3,  4'd7,  16'h0000, 2'd0, 4'd5,  1'b1, 1'b1};
    t[4] = '{16'hA47E, 16'h0002, 4'd1,  4'd0,  16'h0000, 2'd2, 4'd9,  1'b1, 1'b1};
    t[5] = '{16'hC123, 16'h0000, 4'd0,  4'd0,  16'h0000, 2'd0, 4'd0,  1'b0, 1'b0};
    t[6] = '{16'h3C3E, 16'h0001, 4'd0,  4'd15, 16'h0000, 2'd0, 4'd15, 1'b1, 1'b1};

    checks = 0; errors = 0; exp_ret = 16'd0;
    rst = 1'b1; instr = 16'd0; instr_valid = 1'b0; flush = 1'b0; resume = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctl", 64'(dut_ctl), 64'd0);
    check("reset_ready", 64'(instr_ready), 64'd1);
    check("reset_halted", 64'(halted), 64'd0);
    check("reset_retired", 64'(retired), 64'd0);
    rst = 1'b0;

    // Decode table: each word issues alone, then an idle cycle follows.
    for (int i = 0; i < 7; i++) begin
      push_one(t[i].instr);
      @(negedge clk);
      if (t[i].cnt) exp_ret = exp_ret + 16'd1;
      check($sformatf("vec%0d_ctl", i), 64'(dut_ctl), 64'(pack_vec(t[i])));
      check($sformatf("vec%0d_retired", i), 64'(retired), 64'(exp_ret));
      @(negedge clk);
      check($sformatf("vec%0d_idle", i), 64'(dut_ctl), 64'd0);
    end

    // HALT, then fill the FIFO while halted and drain after resume.
    push_one(HALT_W);
    @(negedge clk);
    check("halt_ctl_idle", 64'(dut_ctl), 64'd0);
    check("halt_halted", 64'(halted), 64'd1);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      check($sformatf("fill%0d_ready", k), 64'(instr_ready), 64'd1);
      instr = t[k].instr; instr_valid = 1'b1;
      exp_q.push_back(pack_vec(t[k]));
    end
    @(negedge clk);
    instr = t[4].instr;
    check("full_ready", 64'(instr_ready), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("full_hold_ready", 64'(instr_ready), 64'd0);
      check("full_hold_ctl", 64'(dut_ctl), 64'd0);
    end
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("resume_halted", 64'(halted), 64'd0);
    check("resume_ready", 64'(instr_ready), 64'd0);
    check("resume_ctl_idle", 64'(dut_ctl), 64'd0);
    exp_q.push_back(pack_vec(t[4]));
    exp_q.push_back(pack_vec(t[5]));
    for (int k = 0; k < DEPTH + 2; k++) begin
      @(negedge clk);
      if (k == 0) check("first_pop_ready", 64'(instr_ready), 64'd1);
      if (k == 1) instr = t[5].instr;
      if (k == 2) instr_valid = 1'b0;
      if (t[k].cnt) exp_ret = exp_ret + 16'd1;
      check($sformatf("drain%0d_ctl", k), 64'(dut_ctl), 64'(exp_q.pop_front()));
    end
    @(negedge clk);
    check("drain_idle", 64'(dut_ctl), 64'd0);
    check("drain_retired", 64'(retired), 64'(exp_ret));

    // Flush with a simultaneous push while halted with three words buffered.
    push_one(HALT_W);
    @(negedge clk);
    check("halt2_halted", 64'(halted), 64'd1);
    for (int k = 0; k < 3; k++) begin
      instr = t[k].instr; instr_valid = 1'b1;
      @(negedge clk);
    end
    instr = t[2].instr; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; instr_valid = 1'b0;
    check("flush_halted", 64'(halted), 64'd0);
    check("flush_ready", 64'(instr_ready), 64'd1);
    check("flush_ctl_idle", 64'(dut_ctl), 64'd0);
    @(negedge clk);
    check("flush_empty_ctl", 64'(dut_ctl), 64'd0);
    check("flush_retired", 64'(retired), 64'(exp_ret));
    push_one(t[6].instr);
    @(negedge clk);
    exp_ret = exp_ret + 16'd1;
    check("post_flush_ctl", 64'(dut_ctl), 64'(pack_vec(t[6])));
    check("post_flush_retired", 64'(retired), 64'(exp_ret));

    // Asynchronous reset in the middle of a stream.
    @(negedge clk);
    instr = t[0].instr; instr_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("stream_ctl", 64'(dut_ctl), 64'(pack_vec(t[0])));
    #2 rst = 1'b1;
    #1;
    check("async_rst_ctl", 64'(dut_ctl), 64'd0);
    check("async_rst_retired", 64'(retired), 64'd0);
    check("async_rst_halted", 64'(halted), 64'd0);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_ctl_idle", 64'(dut_ctl), 64'd0);
      check("post_rst_ready", 64'(instr_ready), 64'd1);
    end
    check("post_rst_retired", 64'(retired), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Instruction-driven controller that sequences the register-file / ALU / flags datapath. It buffers 16-bit micro-instructions from a valid/ready producer in a small FIFO and issues one per cycle. Each issued instruction is decoded into registered datapath controls: reg_en, reg_a, reg_b, imm, b_sel, opcode and flag_en. It also provides NOP bubbles, a sticky HALT with resume, flush, and a retired-instruction counter. The block replaces the hard-coded test sequencers in front of the datapath.

Parameters:
DEPTH, 4, instruction FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
instr  input  16  micro-instruction word
instr_valid  input  1  producer has a word on instr
instr_ready  output  1  FIFO can accept a word; equals (count < DEPTH)
flush  input  1  discard buffered instructions and clear halt
resume  input  1  leave HALTED state
reg_en  output  16  one-hot register write enable
reg_a  output  4  register-file read address A (rd)
reg_b  output  4  register-file read address B (rs)
imm  output  16  sign-extended immediate
b_sel  output  2  ALU B mux select: 0=reg, 1=imm, 2=flags
opcode  output  4  ALU opcode
flag_en  output  1  flags register write enable
halted  output  1  sequencer in HALTED state
retired  output  16  count of issued ALU instructions

Behaviour:
- Encoding, by fmt = instr[15:14]:
  - 00 R: opcode=[13:10], rd=[9:6], rs=[5:2], set_flags=[1], no_wb=[0]; b_sel=0.
  - 01 I: opcode=[13:10], rd=[9:6], imm={{10{[5]}},[5:0]}; b_sel=1; flag_en=1; writeback always.
  - 10 F: opcode=[13:10], rd=[9:6], set_flags=[1], no_wb=[0]; b_sel=2.
  - 11 S: [13]=1 HALT, [13]=0 NOP; other bits ignored.
- Field mapping: reg_a=rd; reg_b=rs (R only, else 0); reg_en=(1<<rd) unless no_wb; imm=0 unless I.
- Reset (async, immediate):
  - FIFO empty; state RUN; halted=0; retired=0.
  - All control outputs 0, including reg_en=0 and flag_en=0.
- Push: accepted on an edge with instr_valid && instr_ready. A push while full is impossible because ready is 0; there is no pass-through when full.
- Issue:
  - In RUN with FIFO non-empty, the head pops at an edge. Decoded controls are registered at that same edge and held for exactly one cycle. The datapath then writes rd and flags at the following edge.
  - Latency: word accepted at edge N, controls valid in cycle N+1..N+2, regfile written at edge N+2.
  - Back-to-back issue every cycle with no hazard stall, because the write lands before the next instruction's read cycle.
- Idle cycle (FIFO empty, HALTED, or NOP issued): reg_en=0, flag_en=0, opcode=0, b_sel=0, reg_a=0, reg_b=0, imm=0.
- HALT:
  - Pops like a NOP and drives idle controls.
  - State becomes HALTED; halted=1 from the next cycle.
  - No further pops; pushes continue until the FIFO is full.
- resume while HALTED: return to RUN at that edge; the first pop occurs on the next edge. resume in RUN is ignored.
- retired: increments by 1 per issued R/I/F instruction, including no_wb ones. NOP and HALT do not count. Wraps 0xFFFF to 0.
- flush, with priority over push, pop and resume:
  - FIFO emptied; state RUN; controls idle on the next cycle.
  - retired is unchanged.
  - A simultaneous push is dropped.
- Simultaneous push and pop with count in 1..DEPTH-1: count unchanged, order preserved.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.

Test Plan:
1. After reset, push R 0x0D10 (op=3, rd=4, rs=4, set_flags=0, wb) -> next cycle reg_en=0x0010, reg_a=4, reg_b=4, b_sel=0, opcode=3, flag_en=0; retired=1.
2. Push I with rd=2, imm6=0x3F -> imm=0xFFFF, b_sel=1, reg_en=0x0004, flag_en=1.
3. Hold instr_valid with DEPTH+2 words while in HALTED -> instr_ready drops after DEPTH accepts. Pulse resume -> words issue one per cycle in order, and ready rises one cycle after the first pop.
4. Stream NOP, then R with no_wb=1 and set_flags=1, then F -> NOP gives an all-zero cycle. The compare gives reg_en=0 with flag_en=1. F gives b_sel=2. retired advances by 2.
5. Push 3 words, then assert flush together with a push -> FIFO empty, the pushed word is discarded, controls idle, halted=0, retired unchanged.
6. Assert rst mid-stream -> outputs go to zero immediately (asynchronously). After release the FIFO is empty and retired=0.
